// File: rtl/soc_miner_job_sched.sv
// soc_miner_job_sched: descriptor FIFO sequencing the memory engine; SOC_MINER_JOB_TIMEOUT_EN adds a wait-state watchdog
module soc_miner_job_sched #(
   parameter int FIFO_DEPTH    = 4,
   parameter int ADDR_WIDTH    = 30,
   parameter int LEN_WIDTH     = 32,
   parameter int TIMEOUT_WIDTH = 16
) (
   input  logic                        Clk,
   input  logic                        RESET,
   input  logic                        enable,
   input  logic                        job_push,
   input  logic [ADDR_WIDTH-1:0]       job_src,
   input  logic [ADDR_WIDTH-1:0]       job_dst,
   input  logic [LEN_WIDTH-1:0]        job_len,
   input  logic                        flush,
   output logic                        job_full,
   output logic [$clog2(FIFO_DEPTH):0] job_count,
   output logic                        overflow,
   output logic                        go_read,
   output logic                        go_write,
   output logic [ADDR_WIDTH-1:0]       source_address,
   output logic [ADDR_WIDTH-1:0]       destination_address,
   output logic [LEN_WIDTH-1:0]        length,
   input  logic                        rd_done,
   input  logic                        wr_done,
   output logic                        busy,
   output logic [15:0]                 jobs_done,
   input  logic [TIMEOUT_WIDTH-1:0]    timeout_limit,
   output logic                        timeout_err,
   input  logic                        err_clear
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [2:0] {IDLE, RD_GO, RD_WAIT, WR_GO, WR_WAIT, DONE} state_t;
   state_t state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] dst_mem [FIFO_DEPTH];
   logic [LEN_WIDTH-1:0] len_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [15:0] done_cnt_q, done_cnt_d;
   logic ovf_q, ovf_d, terr_q, terr_d;
   logic full, push_ok, pop, tmo_hit;

`ifdef SOC_MINER_JOB_TIMEOUT_EN
   logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
   logic in_wait;
   always_comb begin
      in_wait = state_q == RD_WAIT || state_q == WR_WAIT;
      tmo_hit = in_wait && timeout_limit != '0 && tmo_q == timeout_limit;
      tmo_d = in_wait ? tmo_q + TIMEOUT_WIDTH'(1) : '0;
   end
   always_ff @(posedge Clk) tmo_q <= RESET ? '0 : tmo_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^timeout_limit;
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      full = count_q == CW'(FIFO_DEPTH);
      push_ok = job_push && !flush && !full;
      pop = state_q == IDLE && enable && count_q != '0 && !terr_q && !flush;
      count_d = flush ? '0 : count_q + CW'(push_ok) - CW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push_ok);
      rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + PW'(pop);
      ovf_d = (job_push && !flush && full) ? 1'b1 : err_clear ? 1'b0 : ovf_q;
      terr_d = tmo_hit ? 1'b1 : err_clear ? 1'b0 : terr_q;
   end

   always_comb begin
      state_d = state_q;
      src_d = src_q;
      dst_d = dst_q;
      len_d = len_q;
      done_cnt_d = done_cnt_q;
      go_read = 1'b0;
      go_write = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               state_d = RD_GO;
               src_d = src_mem[rd_ptr_q];
               dst_d = dst_mem[rd_ptr_q];
               len_d = len_mem[rd_ptr_q];
            end
         end
         RD_GO: begin
            go_read = len_q != '0;
            state_d = len_q == '0 ? DONE : RD_WAIT;
         end
         RD_WAIT: state_d = tmo_hit ? IDLE : rd_done ? WR_GO : RD_WAIT;
         WR_GO: begin
            go_write = 1'b1;
            state_d = WR_WAIT;
         end
         WR_WAIT: state_d = tmo_hit ? IDLE : wr_done ? DONE : WR_WAIT;
         DONE: begin
            done_cnt_d = done_cnt_q + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (RESET) begin
         state_q <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         src_q <= '0;
         dst_q <= '0;
         len_q <= '0;
         done_cnt_q <= '0;
         ovf_q <= 1'b0;
         terr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         src_q <= src_d;
         dst_q <= dst_d;
         len_q <= len_d;
         done_cnt_q <= done_cnt_d;
         ovf_q <= ovf_d;
         terr_q <= terr_d;
      end
   end

   // storage needs no reset: occupancy is tracked by count_q
   always_ff @(posedge Clk) begin
      if (push_ok) begin
         src_mem[wr_ptr_q] <= job_src;
         dst_mem[wr_ptr_q] <= job_dst;
         len_mem[wr_ptr_q] <= job_len;
      end
   end

   assign job_full = full;
   assign job_count = count_q;
   assign overflow = ovf_q;
   assign timeout_err = terr_q;
   assign busy = state_q != IDLE;
   assign jobs_done = done_cnt_q;
   assign source_address = src_q;
   assign destination_address = dst_q;
   assign length = len_q;
endmodule

// File: tb/tb_soc_miner_job_sched.sv
// tb_soc_miner_job_sched: randomized descriptor traffic against a queue model of the scheduler
module tb_soc_miner_job_sched;
   localparam int D = 4;
   localparam int AW = 30;
   localparam int LW = 32;
   localparam int TW = 16;
   typedef struct packed {
      logic [AW-1:0] s;
      logic [AW-1:0] d;
      logic [LW-1:0] l;
   } desc_t;
   logic Clk = 1'b0;
   logic RESET = 1'b1;
   logic enable = 1'b0;
   logic job_push = 1'b0;
   logic [AW-1:0] job_src = '0;
   logic [AW-1:0] job_dst = '0;
   logic [LW-1:0] job_len = '0;
   logic flush = 1'b0;
   logic rd_done = 1'b0;
   logic wr_done = 1'b0;
   logic [TW-1:0] timeout_limit = '0;
   logic err_clear = 1'b0;
   logic job_full, overflow, go_read, go_write, busy, timeout_err;
   logic [$clog2(D):0] job_count;
   logic [AW-1:0] source_address, destination_address;
   logic [LW-1:0] length;
   logic [15:0] jobs_done;
   int vectors = 0;
   int miscompares = 0;
   desc_t mq[$];
   logic [15:0] m_done = '0;
   bit m_ovf = 1'b0;
   int r_nrd, r_nwr, r_rd_at, r_wr_at, r_wd_at, r_done_at;
   bit r_fin, r_stable, r_busy_end;
   desc_t r_got;

   soc_miner_job_sched #(.FIFO_DEPTH(D), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_WIDTH(TW)) dut (
      .Clk(Clk), .RESET(RESET), .enable(enable), .job_push(job_push), .job_src(job_src),
      .job_dst(job_dst), .job_len(job_len), .flush(flush), .job_full(job_full), .job_count(job_count),
      .overflow(overflow), .go_read(go_read), .go_write(go_write), .source_address(source_address),
      .destination_address(destination_address), .length(length), .rd_done(rd_done), .wr_done(wr_done),
      .busy(busy), .jobs_done(jobs_done), .timeout_limit(timeout_limit), .timeout_err(timeout_err),
      .err_clear(err_clear)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "time limit");
   end

   function automatic desc_t rand_desc(input bit zero_len);
      desc_t x;
      x.s = AW'($urandom());
      x.d = AW'($urandom());
      x.l = zero_len ? '0 : LW'($urandom_range(1, 5000));
      return x;
   endfunction

   // drive one push; model accepts it only while fewer than D are queued
   task automatic push(input desc_t x);
      @(negedge Clk);
      job_push = 1'b1;
      job_src = x.s;
      job_dst = x.d;
      job_len = x.l;
      if (mq.size() < D) mq.push_back(x);
      else m_ovf = 1'b1;
      @(negedge Clk);
      job_push = 1'b0;
   endtask

   // engine responder and monitor for one job; results left in r_* for the caller to judge
   task automatic serve(input int rdly, input int wdly, input bit spur, input bit fl);
      logic [15:0] start;
      desc_t cur;
      int t;
      start = jobs_done;
      r_nrd = 0; r_nwr = 0; r_rd_at = -1; r_wr_at = -1; r_wd_at = -1; r_done_at = -1;
      r_fin = 1'b0; r_stable = 1'b1; r_busy_end = 1'b1; r_got = '0;
      t = 0;
      while (t < 300 && !r_fin) begin
         @(negedge Clk);
         rd_done = 1'b0;
         wr_done = 1'b0;
         flush = 1'b0;
         job_push = 1'b0;
         cur = {source_address, destination_address, length};
         if (go_read) begin
            r_nrd++;
            r_rd_at = t;
            r_got = cur;
         end else if (r_nrd > 0 && cur !== r_got) r_stable = 1'b0;
         if (go_write) begin
            r_nwr++;
            r_wr_at = t;
         end
         if (jobs_done !== start) begin
            r_fin = 1'b1;
            r_done_at = t;
            r_busy_end = busy;
            if (r_nrd == 0) r_got = cur;
         end
         if (r_rd_at >= 0 && r_nwr == 0 && (t == r_rd_at + rdly || (spur && t == r_rd_at))) rd_done = 1'b1;
         if (r_wr_at >= 0 && t == r_wr_at + wdly) begin
            wr_done = 1'b1;
            r_wd_at = t;
         end
         if (spur && r_wr_at == t) wr_done = 1'b1;
         if (fl && r_rd_at >= 0 && t == r_rd_at + 1) begin
            flush = 1'b1;
            job_push = 1'b1;
            job_src = AW'($urandom());
         end
         t++;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(negedge Clk);
      vectors++;
      if ({go_read, go_write, busy, job_full, overflow, timeout_err} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags got %b exp 000000", {go_read, go_write, busy, job_full, overflow, timeout_err});
      end
      vectors++;
      if (job_count !== '0 || jobs_done !== '0) begin
         miscompares++;
         $display("FAIL reset_counts got count=%0d done=%0d exp 0/0", job_count, jobs_done);
      end
      vectors++;
      if ({source_address, destination_address, length} !== '0) begin
         miscompares++;
         $display("FAIL reset_job_regs got %h/%h/%h exp 0", source_address, destination_address, length);
      end
      RESET = 1'b0;
   endtask

   task automatic test_single();
      desc_t exp;
      enable = 1'b1;
      exp.s = 30'h100;
      exp.d = 30'h200;
      exp.l = 32'd16;
      push(exp);
      exp = mq.pop_front();
      serve(5, 5, 1'b0, 1'b0);
      m_done++;
      vectors++;
      if (!r_fin || r_nrd != 1 || r_nwr != 1) begin
         miscompares++;
         $display("FAIL single_pulses got fin=%0d rd=%0d wr=%0d exp 1/1/1", r_fin, r_nrd, r_nwr);
      end
      vectors++;
      if (r_got !== exp || !r_stable) begin
         miscompares++;
         $display("FAIL single_outputs got %h stable=%0d exp %h stable=1", r_got, r_stable, exp);
      end
      vectors++;
      if (r_rd_at != 0 || r_wr_at != r_rd_at + 6) begin
         miscompares++;
         $display("FAIL single_go_timing got rd@%0d wr@%0d exp rd@0 wr@6", r_rd_at, r_wr_at);
      end
      vectors++;
      if (r_done_at != r_wd_at + 2 || r_busy_end !== 1'b0 || jobs_done !== m_done) begin
         miscompares++;
         $display("FAIL single_done got at=%0d busy=%0b cnt=%0d exp at=%0d busy=0 cnt=%0d",
                  r_done_at, r_busy_end, jobs_done, r_wd_at + 2, m_done);
      end
      repeat (3) @(negedge Clk);
      vectors++;
      if (source_address !== exp.s || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_idle_hold got src=%h busy=%0b exp src=%h busy=0", source_address, busy, exp.s);
      end
   endtask

   task automatic test_overflow();
      desc_t exp;
      enable = 1'b0;
      for (int i = 0; i < 5; i++) push(rand_desc(1'b0));
      vectors++;
      if (job_full !== 1'b1 || job_count !== 3'(D) || overflow !== m_ovf) begin
         miscompares++;
         $display("FAIL ovf_full got full=%0b count=%0d ovf=%0b exp 1/%0d/%0b", job_full, job_count, overflow, D, m_ovf);
      end
      @(negedge Clk);
      job_push = 1'b1;
      err_clear = 1'b1;
      @(negedge Clk);
      job_push = 1'b0;
      err_clear = 1'b0;
      vectors++;
      if (overflow !== 1'b1 || job_count !== 3'(D)) begin
         miscompares++;
         $display("FAIL ovf_set_wins got ovf=%0b count=%0d exp 1/%0d", overflow, job_count, D);
      end
      err_clear = 1'b1;
      @(negedge Clk);
      err_clear = 1'b0;
      m_ovf = 1'b0;
      vectors++;
      if (overflow !== m_ovf) begin
         miscompares++;
         $display("FAIL ovf_clear got %0b exp 0", overflow);
      end
      enable = 1'b1;
      for (int i = 0; i < D; i++) begin
         exp = mq.pop_front();
         serve($urandom_range(1, 6), $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
         m_done++;
         vectors++;
         if (!r_fin || r_got !== exp || r_nrd != 1 || r_nwr != 1 || jobs_done !== m_done) begin
            miscompares++;
            $display("FAIL ovf_drain%0d got fin=%0d job=%h rd=%0d wr=%0d cnt=%0d exp job=%h cnt=%0d",
                     i, r_fin, r_got, r_nrd, r_nwr, jobs_done, exp, m_done);
         end
      end
      vectors++;
      if (job_count !== '0 || job_full !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_empty got count=%0d full=%0b exp 0/0", job_count, job_full);
      end
   endtask

   task automatic test_len0();
      desc_t exp;
      enable = 1'b1;
      push(rand_desc(1'b1));
      exp = mq.pop_front();
      serve(2, 2, 1'b1, 1'b0);
      m_done++;
      vectors++;
      if (!r_fin || r_nrd != 0 || r_nwr != 0 || r_done_at != 2) begin
         miscompares++;
         $display("FAIL len0_pulses got fin=%0d rd=%0d wr=%0d at=%0d exp 1/0/0/2", r_fin, r_nrd, r_nwr, r_done_at);
      end
      vectors++;
      if (r_got !== exp || jobs_done !== m_done || r_busy_end !== 1'b0) begin
         miscompares++;
         $display("FAIL len0_done got job=%h cnt=%0d busy=%0b exp job=%h cnt=%0d busy=0",
                  r_got, jobs_done, r_busy_end, exp, m_done);
      end
   endtask

   task automatic test_flush();
      desc_t exp;
      bit saw_busy;
      enable = 1'b0;
      for (int i = 0; i < 3; i++) push(rand_desc(1'b0));
      enable = 1'b1;
      exp = mq.pop_front();
      serve(6, 3, 1'b0, 1'b1);
      mq.delete();
      m_done++;
      vectors++;
      if (!r_fin || r_got !== exp || r_nrd != 1 || r_nwr != 1 || jobs_done !== m_done) begin
         miscompares++;
         $display("FAIL flush_active got fin=%0d job=%h cnt=%0d exp job=%h cnt=%0d", r_fin, r_got, jobs_done, exp, m_done);
      end
      vectors++;
      if (job_count !== 3'(mq.size()) || overflow !== m_ovf) begin
         miscompares++;
         $display("FAIL flush_empty got count=%0d ovf=%0b exp 0/%0b", job_count, overflow, m_ovf);
      end
      saw_busy = 1'b0;
      repeat (8) begin
         @(negedge Clk);
         saw_busy |= busy | go_read;
      end
      vectors++;
      if (saw_busy || job_count !== '0) begin
         miscompares++;
         $display("FAIL flush_no_more got busy=%0b count=%0d exp 0/0", saw_busy, job_count);
      end
   endtask

   task automatic test_timeout();
      desc_t exp;
      bit seen, saw_gw, err8, err10, busy10;
      int t;
      timeout_limit = TW'(8);
      enable = 1'b0;
      for (int i = 0; i < 2; i++) push(rand_desc(1'b0));
      enable = 1'b1;
      seen = 1'b0;
      t = 0;
      while (t < 20 && !seen) begin
         @(negedge Clk);
         seen = go_read;
         t++;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL tmo_start got no go_read exp go_read within 20 cycles");
      end
      saw_gw = 1'b0; err8 = 1'b0; err10 = 1'b0; busy10 = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge Clk);
         saw_gw |= go_write;
         if (k == 8) err8 = timeout_err;
         if (k == 10) begin
            err10 = timeout_err;
            busy10 = busy;
         end
      end
`ifdef SOC_MINER_JOB_TIMEOUT_EN
      vectors++;
      if (err8 !== 1'b0 || err10 !== 1'b1 || busy10 !== 1'b0 || saw_gw) begin
         miscompares++;
         $display("FAIL tmo_fire got err8=%0b err10=%0b busy=%0b gw=%0b exp 0/1/0/0", err8, err10, busy10, saw_gw);
      end
      repeat (4) @(negedge Clk);
      vectors++;
      if (job_count !== 3'd1 || busy !== 1'b0 || jobs_done !== m_done) begin
         miscompares++;
         $display("FAIL tmo_blocked got count=%0d busy=%0b cnt=%0d exp 1/0/%0d", job_count, busy, jobs_done, m_done);
      end
      err_clear = 1'b1;
      @(negedge Clk);
      err_clear = 1'b0;
      void'(mq.pop_front());
      exp = mq.pop_front();
      serve(3, 3, 1'b0, 1'b0);
      m_done++;
      vectors++;
      if (!r_fin || r_got !== exp || jobs_done !== m_done || timeout_err !== 1'b0) begin
         miscompares++;
         $display("FAIL tmo_resume got fin=%0d job=%h cnt=%0d err=%0b exp job=%h cnt=%0d err=0",
                  r_fin, r_got, jobs_done, timeout_err, exp, m_done);
      end
`else
      exp = '0;
      vectors++;
      if (err10 !== 1'b0 || busy10 !== 1'b1 || saw_gw || job_count !== 3'd1) begin
         miscompares++;
         $display("FAIL tmo_disabled got err=%0b busy=%0b gw=%0b count=%0d exp 0/1/0/1", err10, busy10, saw_gw, job_count);
      end
      RESET = 1'b1;
      repeat (2) @(negedge Clk);
      RESET = 1'b0;
      mq.delete();
      m_done = '0;
      m_ovf = 1'b0;
`endif
      timeout_limit = '0;
   endtask

   task automatic test_reset_mid();
      bit seen, gw, stray;
      int t;
      enable = 1'b0;
      for (int i = 0; i < 3; i++) push(rand_desc(1'b0));
      enable = 1'b1;
      seen = 1'b0;
      t = 0;
      while (t < 20 && !seen) begin
         @(negedge Clk);
         seen = go_read;
         t++;
      end
      repeat (2) @(negedge Clk);
      rd_done = 1'b1;
      @(negedge Clk);
      rd_done = 1'b0;
      gw = go_write;
      vectors++;
      if (!seen || !gw) begin
         miscompares++;
         $display("FAIL rstmid_reach got rd=%0b wr=%0b exp 1/1", seen, gw);
      end
      @(negedge Clk);
      RESET = 1'b1;
      @(negedge Clk);
      RESET = 1'b0;
      mq.delete();
      m_done = '0;
      m_ovf = 1'b0;
      vectors++;
      if ({go_read, go_write, busy, job_full, overflow, timeout_err} !== 6'b0 || job_count !== '0 ||
          jobs_done !== m_done || {source_address, destination_address, length} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_values got flags=%b count=%0d done=%0d regs=%h exp all zero",
                  {go_read, go_write, busy, job_full, overflow, timeout_err}, job_count, jobs_done,
                  {source_address, destination_address, length});
      end
      wr_done = 1'b1;
      @(negedge Clk);
      wr_done = 1'b0;
      stray = 1'b0;
      repeat (10) begin
         @(negedge Clk);
         stray |= go_read | go_write | busy;
      end
      vectors++;
      if (stray || jobs_done !== m_done || job_count !== '0) begin
         miscompares++;
         $display("FAIL rstmid_late_done got stray=%0b cnt=%0d count=%0d exp 0/0/0", stray, jobs_done, job_count);
      end
   endtask

   task automatic test_back_to_back();
      desc_t exp;
      int n, rdly;
      for (int round = 0; round < 8; round++) begin
         enable = 1'b0;
         n = $urandom_range(1, D);
         for (int i = 0; i < n; i++) push(rand_desc($urandom_range(0, 3) == 0));
         enable = 1'b1;
         for (int i = 0; i < n; i++) begin
            exp = mq.pop_front();
            rdly = $urandom_range(1, 6);
            serve(rdly, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
            m_done++;
            vectors++;
            if (!r_fin || r_got !== exp || !r_stable || jobs_done !== m_done) begin
               miscompares++;
               $display("FAIL b2b_job r%0d.%0d got fin=%0d job=%h stable=%0d cnt=%0d exp job=%h cnt=%0d",
                        round, i, r_fin, r_got, r_stable, jobs_done, exp, m_done);
            end
            vectors++;
            if (exp.l != 0 ? (r_nrd != 1 || r_nwr != 1 || r_wr_at != r_rd_at + rdly + 1 || r_done_at != r_wd_at + 2)
                           : (r_nrd != 0 || r_nwr != 0 || r_done_at != 2)) begin
               miscompares++;
               $display("FAIL b2b_timing r%0d.%0d got rd=%0d@%0d wr=%0d@%0d done@%0d len=%0d",
                        round, i, r_nrd, r_rd_at, r_nwr, r_wr_at, r_done_at, exp.l);
            end
         end
         vectors++;
         if (job_count !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain r%0d got count=%0d busy=%0b exp 0/0", round, job_count, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_len0();
      test_flush();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
